// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte from the host to a PS/2 device.
//
// A frame runs through these steps:
//   1. Inhibit: hold the clock line low.
//   2. Request: pull data low to form the start bit, then release the clock.
//   3. Send: shift out 8 data bits LSB first, then odd parity, then the stop bit.
//      The device's falling clock edges pace each bit.
//   4. Acknowledge: on the next falling edge, sample the device's ack bit.
//   5. Wait for both lines to go idle, then pulse done.
// If the device stops clocking, a timeout aborts the frame and releases the bus.
//
// Ports:
//   clk, resetn           system clock; asynchronous active-low reset
//   tx_data, tx_valid     command byte and request strobe
//   tx_ready              high in IDLE; accept = tx_valid && tx_ready
//   ps2_clk, ps2_data     raw pad senses (asynchronous)
//   ps2_clk_oe            1 pulls the clock line low
//   ps2_data_oe           1 pulls the data line low
//   busy                  high in every state except IDLE
//   done                  one-cycle pulse at the end of a frame
//   ack_ok                device acknowledged with 0; held until the next accept
//   err_timeout           frame aborted by timeout; held until the next accept
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err_timeout
);

  localparam int unsigned InhW = (INHIBIT_CYCLES < 2) ? 1 : $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TmoW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StSend,
    StAck,
    StWaitIdle,
    StDone
  } state_e;

  state_e          r_state;
  logic [9:0]      r_shreg;
  logic [3:0]      r_cnt;
  logic [InhW-1:0] r_inh;
  logic [TmoW-1:0] r_tmo;
  logic            r_clk_oe;
  logic            r_data_oe;
  logic            r_done;
  logic            r_ack_ok;
  logic            r_err;

  // Pad synchronizers. Reset to 1 because an idle bus reads high.
  logic r_clk_s1, r_clk_s2, r_clk_h;
  logic r_data_s1, r_data_s2;
  logic r_fe;
  logic w_clk_fe;
  logic w_tmo_hit;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_clk_s1  <= 1'b1;
      r_clk_s2  <= 1'b1;
      r_clk_h   <= 1'b1;
      r_data_s1 <= 1'b1;
      r_data_s2 <= 1'b1;
      r_fe      <= 1'b0;
    end else begin
      r_clk_s1  <= ps2_clk;
      r_clk_s2  <= r_clk_s1;
      r_clk_h   <= r_clk_s2;
      r_data_s1 <= ps2_data;
      r_data_s2 <= r_data_s1;
      r_fe      <= w_clk_fe;
    end
  end

  assign w_clk_fe  = r_clk_h & ~r_clk_s2;
  assign w_tmo_hit = (r_tmo >= TmoLast);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= StIdle;
      r_shreg   <= 10'h3ff;
      r_cnt     <= 4'd0;
      r_inh     <= '0;
      r_tmo     <= '0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_done    <= 1'b0;
      r_ack_ok  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          if (tx_valid) begin
            // Frame order on the wire after the start bit: data LSB first, odd parity, stop.
            r_shreg  <= {1'b1, ~^tx_data, tx_data};
            r_ack_ok <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= 4'd0;
            r_inh    <= '0;
            r_clk_oe <= 1'b1;
            r_state  <= StInhibit;
          end
        end
        StInhibit: begin
          if (r_inh == InhLast) begin
            r_data_oe <= 1'b1;
            r_state   <= StReq;
          end else begin
            r_inh <= r_inh + 1'b1;
          end
        end
        StReq: begin
          // Release the clock so the device starts clocking. The start bit stays
          // on the line until the first falling edge.
          r_clk_oe <= 1'b0;
          r_tmo    <= TmoW'(1);
          r_state  <= StSend;
        end
        StSend, StAck, StWaitIdle: begin
          if (w_tmo_hit) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_err     <= 1'b1;
            r_ack_ok  <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= StDone;
          end else begin
            r_tmo <= r_tmo + 1'b1;
            if (r_state == StSend) begin
              if (r_fe) begin
                r_data_oe <= ~r_shreg[0];
                r_shreg   <= {1'b1, r_shreg[9:1]};
                r_cnt     <= r_cnt + 4'd1;
                // On the 10th edge the stop bit (1) goes out, which releases data.
                if (r_cnt == 4'd9) r_state <= StAck;
              end
            end else if (r_state == StAck) begin
              if (r_fe) begin
                r_ack_ok <= ~r_data_s2;
                r_cnt    <= r_cnt + 4'd1;
                r_state  <= StWaitIdle;
              end
            end else begin
              if (r_clk_s2 && r_data_s2) begin
                r_done  <= 1'b1;
                r_state <= StDone;
              end
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          r_state   <= StIdle;
        end
      endcase
    end
  end

  assign tx_ready    = (r_state == StIdle);
  assign busy        = (r_state != StIdle);
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign done        = r_done;
  assign ack_ok      = r_ack_ok;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

  localparam int unsigned InhCycles = 50;
  localparam int unsigned TmoCycles = 2000;

  logic       clk;
  logic       resetn;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_line;
  logic       ps2_data_line;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       ack_ok;
  logic       err_timeout;
  logic       dev_clk_low;
  logic       dev_data_low;

  int n_checks = 0;
  int n_pass   = 0;

  // Open-drain bus: low if either side pulls.
  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(InhCycles),
    .TIMEOUT_CYCLES(TmoCycles)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk    (ps2_clk_line),
    .ps2_data   (ps2_data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .ack_ok     (ack_ok),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Issue a request and measure the inhibit/request phase. Returns on the first
  // negedge after the clock line is released.
  task automatic start_req(input logic [7:0] d, output int hi, output int dpos, output int dcnt);
    int w;
    w = 0;
    while (!tx_ready && w < 1000) begin @(negedge clk); w++; end
    chk("tx_ready before request", 32'(tx_ready), 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    hi = 0; dpos = 0; dcnt = 0;
    while (ps2_clk_oe && hi < 1000) begin
      hi++;
      if (ps2_data_oe) begin dcnt++; dpos = hi; end
      @(negedge clk);
    end
  endtask

  // Full frame with a device model: 10 data-phase clocks, then the ack clock.
  task automatic run_frame(input logic [7:0] d, input logic ack_bit, input logic inject,
                           output logic [10:0] bits, output logic got_done,
                           output logic got_ack, output logic got_err,
                           output int hi, output int dpos, output int dcnt);
    start_req(d, hi, dpos, dcnt);
    repeat (10) @(negedge clk);
    bits[0] = ps2_data_line;
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      if (inject && i == 5) begin
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (19) @(negedge clk);
      end else begin
        repeat (20) @(negedge clk);
      end
      bits[i] = ps2_data_line;
      dev_clk_low = 1'b0;
      repeat (20) @(negedge clk);
    end
    dev_data_low = ~ack_bit;
    repeat (5) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (20) @(negedge clk);
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    got_done = 1'b0; got_ack = 1'b0; got_err = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) begin
        got_done = 1'b1;
        got_ack  = ack_ok;
        got_err  = err_timeout;
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        ack_bit;
    logic        inject;
    logic [10:0] exp_bits;  // {stop, parity, data[7:0], start}
    logic        exp_ack_ok;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [10:0] bits;
    logic        gd, ga, ge;
    int          hi, dpos, dcnt, cyc;

    vecs[0] = '{8'hED, 1'b0, 1'b0, 11'b1_1_11101101_0, 1'b1};
    vecs[1] = '{8'h00, 1'b1, 1'b0, 11'b1_1_00000000_0, 1'b0};
    vecs[2] = '{8'hFF, 1'b0, 1'b0, 11'b1_1_11111111_0, 1'b1};
    vecs[3] = '{8'h07, 1'b0, 1'b1, 11'b1_0_00000111_0, 1'b1};
    vecs[4] = '{8'h55, 1'b0, 1'b0, 11'b1_1_01010101_0, 1'b1};
    vecs[5] = '{8'h01, 1'b1, 1'b0, 11'b1_0_00000001_0, 1'b0};

    resetn = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("reset data_oe", 32'(ps2_data_oe), 32'd0);
    chk("reset tx_ready", 32'(tx_ready), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset ack_ok/err", {30'd0, ack_ok, err_timeout}, 32'd0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].data, vecs[v].ack_bit, vecs[v].inject, bits, gd, ga, ge, hi, dpos, dcnt);
      chk($sformatf("v%0d clk_oe high cycles", v), 32'(hi), 32'(InhCycles + 1));
      chk($sformatf("v%0d data_oe only in last", v), 32'(dpos * 8 + dcnt),
          32'((InhCycles + 1) * 8 + 1));
      chk($sformatf("v%0d frame bits", v), 32'(bits), 32'(vecs[v].exp_bits));
      chk($sformatf("v%0d done seen", v), 32'(gd), 32'd1);
      chk($sformatf("v%0d ack_ok", v), 32'(ga), 32'(vecs[v].exp_ack_ok));
      chk($sformatf("v%0d err_timeout", v), 32'(ge), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d done one cycle/ready", v), {30'd0, done, tx_ready}, 32'd1);
    end

    // Timeout: no device clocks at all.
    start_req(8'h12, hi, dpos, dcnt);
    chk("tmo clk_oe high cycles", 32'(hi), 32'(InhCycles + 1));
    cyc = 1;
    while (!done && cyc < 3000) begin @(negedge clk); cyc++; end
    chk("tmo done after REQ", 32'(cyc), 32'(TmoCycles));
    chk("tmo err_timeout", 32'(err_timeout), 32'd1);
    chk("tmo ack_ok", 32'(ack_ok), 32'd0);
    chk("tmo oe released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    @(negedge clk);
    chk("tmo tx_ready next", 32'(tx_ready), 32'd1);
    chk("tmo flags held", {30'd0, ack_ok, err_timeout}, 32'd1);

    // Reset mid-frame after the 4th falling edge.
    start_req(8'hED, hi, dpos, dcnt);
    repeat (10) @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      dev_clk_low = 1'b1;
      repeat (20) @(negedge clk);
      if (i < 4) begin
        dev_clk_low = 1'b0;
        repeat (20) @(negedge clk);
      end
    end
    chk("pre-reset busy", 32'(busy), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("mid reset oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    chk("mid reset busy", 32'(busy), 32'd0);
    chk("mid reset tx_ready", 32'(tx_ready), 32'd1);
    dev_clk_low = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    run_frame(8'hED, 1'b0, 1'b0, bits, gd, ga, ge, hi, dpos, dcnt);
    chk("post-reset frame bits", 32'(bits), 32'(11'b1_1_11101101_0));
    chk("post-reset done", 32'(gd), 32'd1);
    chk("post-reset ack_ok", 32'(ga), 32'd1);
    chk("post-reset err", 32'(ge), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
